// File: rtl/hoplite_inj_ctrl_pkg.sv
// Shared Hoplite packet definitions plus injection-controller FSM encoding.
// Latency: none (types and constants only).
// Backpressure: n/a.
package hoplite_inj_ctrl_pkg;

  // Packet width shared with the torus switch.
  localparam int HOPLITE_P_W = 32;

  typedef logic [HOPLITE_P_W-1:0] hoplite_pkt_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } inj_state_e;

endpackage

// File: rtl/hoplite_inj_ctrl_if.sv
// Requester-side and switch-side injection handshake bundle.
// Latency: none (wires only).
// Backpressure: req_rdy towards requesters, peout_rdy from the switch.
interface hoplite_inj_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int P_W   = hoplite_inj_ctrl_pkg::HOPLITE_P_W
);
  logic [N_REQ*P_W-1:0] req_pkt;
  logic [N_REQ-1:0]     req_vld;
  logic [N_REQ-1:0]     req_rdy;
  logic [P_W-1:0]       pein_pkt;
  logic                 pein_vld;
  logic                 peout_rdy;

  // Requesters and switch side (drives packets in, accepts pein).
  modport master (
    output req_pkt, req_vld, peout_rdy,
    input  req_rdy, pein_pkt, pein_vld
  );

  // Injection controller side.
  modport slave (
    input  req_pkt, req_vld, peout_rdy,
    output req_rdy, pein_pkt, pein_vld
  );
endinterface

// File: rtl/hoplite_inj_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, upward with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the grant is consumed.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             any
);

  // Scan N slots starting at ptr; the first set request wins.
  always_comb begin
    int idx;
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hoplite_inj_ctrl.sv
// Shares the Hoplite PE injection port among N_REQ requesters via 2-entry buffers + RR lock.
// Latency: push into empty buffer at edge t -> pein_vld after edge t+1; back-to-back on accept.
// Backpressure: locked packet held until peout_rdy; req_rdy registered per buffer.
// Optional token-bucket rate regulator: define HOPLITE_INJ_REGULATOR_EN.
module hoplite_inj_ctrl
  import hoplite_inj_ctrl_pkg::*;
#(
  parameter int P_W           = HOPLITE_P_W,
  parameter int N_REQ         = 4,
  parameter int CNT_W         = 16,
  parameter int BKT_W         = 4,
  parameter int BKT_MAX       = 4,
  parameter int REFILL_PERIOD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  hoplite_inj_ctrl_if.slave      bus,
  output logic [CNT_W-1:0]       inj_cnt,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam bit CFG_OK = (N_REQ >= 2) && (N_REQ <= 8) && (REFILL_PERIOD >= 1) &&
                          (BKT_MAX >= 1) && (BKT_MAX <= (2**BKT_W) - 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("hoplite_inj_ctrl: illegal parameter combination");
  end

  logic [P_W-1:0]   ent0_q [N_REQ];
  logic [P_W-1:0]   ent0_d [N_REQ];
  logic [P_W-1:0]   ent1_q [N_REQ];
  logic [P_W-1:0]   ent1_d [N_REQ];
  logic [1:0]       occ_q  [N_REQ];
  logic [1:0]       occ_d  [N_REQ];
  logic [N_REQ-1:0] req_rdy_q, req_rdy_d;

  inj_state_e       state_q, state_d;
  logic [PTR_W-1:0] win_q, win_d, rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] win_inc, arb_ptr, gnt_idx;
  logic             pein_vld_q, pein_vld_d;
  logic [P_W-1:0]   pein_pkt_q, pein_pkt_d, head_nxt;
  logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d, stall_cnt_q, stall_cnt_d;

  logic             accept;
  logic [N_REQ-1:0] pop, push, elig, gnt;
  logic             any;

  // Handshake decode and registered outputs.
  always_comb begin
    accept = (state_q == ST_LOCKED) && bus.peout_rdy;
    pop    = '0;
    push   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pop[i]  = accept && (win_q == PTR_W'(i));
      push[i] = bus.req_vld[i] && req_rdy_q[i];
    end
    win_inc = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
    arb_ptr = accept ? win_inc : rr_ptr_q;
  end

  assign bus.req_rdy  = req_rdy_q;
  assign bus.pein_vld = pein_vld_q;
  assign bus.pein_pkt = pein_pkt_q;
  assign inj_cnt      = inj_cnt_q;
  assign stall_cnt    = stall_cnt_q;

`ifdef HOPLITE_INJ_REGULATOR_EN
  logic [BKT_W-1:0] bkt_q [N_REQ];
  logic [BKT_W-1:0] bkt_d [N_REQ];
  logic [15:0]      tmr_q, tmr_d;
  logic             refill;

  // Token buckets: eligibility needs a token left after this cycle's accept.
  always_comb begin
    refill = (tmr_q == 16'(REFILL_PERIOD - 1));
    tmr_d  = refill ? '0 : tmr_q + 16'd1;
    for (int i = 0; i < N_REQ; i++) begin
      bkt_d[i] = bkt_q[i];
      if (pop[i] && !(refill && bkt_q[i] < BKT_W'(BKT_MAX)))
        bkt_d[i] = bkt_q[i] - BKT_W'(1);
      else if (!pop[i] && refill && bkt_q[i] < BKT_W'(BKT_MAX))
        bkt_d[i] = bkt_q[i] + BKT_W'(1);
      elig[i] = (occ_q[i] > 2'(pop[i])) && (bkt_q[i] > BKT_W'(pop[i]));
    end
  end

  // Bucket and refill-timer state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0;
      for (int i = 0; i < N_REQ; i++) bkt_q[i] <= BKT_W'(BKT_MAX);
    end else begin
      tmr_q <= tmr_d;
      for (int i = 0; i < N_REQ; i++) bkt_q[i] <= bkt_d[i];
    end
  end
`else
  // Without regulation a buffer is eligible whenever it keeps a packet after any pop.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) elig[i] = occ_q[i] > 2'(pop[i]);
  end
`endif

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req (elig),
    .ptr (arb_ptr),
    .gnt (gnt),
    .any (any)
  );

  // Winner index and the head it will present next cycle.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
    head_nxt = pop[gnt_idx] ? ent1_q[gnt_idx] : ent0_q[gnt_idx];
  end

  // 2-entry shift buffers: pop shifts entry 1 down, push fills the first free slot.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ent0_d[i] = ent0_q[i];
      ent1_d[i] = ent1_q[i];
      if (pop[i]) ent0_d[i] = ent1_q[i];
      if (push[i]) begin
        if ((occ_q[i] - 2'(pop[i])) == 2'd0) ent0_d[i] = bus.req_pkt[i*P_W +: P_W];
        else                                 ent1_d[i] = bus.req_pkt[i*P_W +: P_W];
      end
      occ_d[i]     = occ_q[i] - 2'(pop[i]) + 2'(push[i]);
      req_rdy_d[i] = (occ_d[i] != 2'd2);
    end
  end

  // Next-state: lock from IDLE, re-arbitrate on accept, hold while stalled.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    rr_ptr_d   = rr_ptr_q;
    pein_vld_d = pein_vld_q;
    pein_pkt_d = pein_pkt_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d    = ST_LOCKED;
          win_d      = gnt_idx;
          pein_vld_d = 1'b1;
          pein_pkt_d = head_nxt;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          rr_ptr_d = win_inc;
          if (any) begin
            win_d      = gnt_idx;
            pein_pkt_d = head_nxt;
          end else begin
            state_d    = ST_IDLE;
            pein_vld_d = 1'b0;
            pein_pkt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating accept / stall statistics.
  always_comb begin
    inj_cnt_d   = inj_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && !(&inj_cnt_q)) inj_cnt_d = inj_cnt_q + CNT_W'(1);
    if ((state_q == ST_LOCKED) && !bus.peout_rdy && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // FSM state register, including the output registers it drives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      rr_ptr_q   <= '0;
      pein_vld_q <= 1'b0;
      pein_pkt_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      rr_ptr_q   <= rr_ptr_d;
      pein_vld_q <= pein_vld_d;
      pein_pkt_q <= pein_pkt_d;
    end
  end

  // Buffer storage, ready flags and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_rdy_q   <= '1;
      inj_cnt_q   <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        ent0_q[i] <= '0;
        ent1_q[i] <= '0;
        occ_q[i]  <= '0;
      end
    end else begin
      req_rdy_q   <= req_rdy_d;
      inj_cnt_q   <= inj_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < N_REQ; i++) begin
        ent0_q[i] <= ent0_d[i];
        ent1_q[i] <= ent1_d[i];
        occ_q[i]  <= occ_d[i];
      end
    end
  end

endmodule

// File: tb/tb_hoplite_inj_ctrl.sv
// Directed bench for hoplite_inj_ctrl: latency, round-robin, stall, fill, reset, regulator.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: peout_rdy driven directly to exercise stall/hold.
module tb_hoplite_inj_ctrl;
  import hoplite_inj_ctrl_pkg::*;

  localparam int N_REQ = 4;
  localparam int P_W   = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] inj_cnt, stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  hoplite_inj_ctrl_if #(.N_REQ(N_REQ), .P_W(P_W)) bus ();

  hoplite_inj_ctrl #(
    .P_W(P_W), .N_REQ(N_REQ), .CNT_W(CNT_W),
    .BKT_W(4), .BKT_MAX(2), .REFILL_PERIOD(8)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus),
    .inj_cnt   (inj_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int i, input hoplite_pkt_t v);
    bus.req_pkt[i*P_W +: P_W] = v;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_vld   = '0;
    bus.req_pkt   = '0;
    bus.peout_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- reset state + single-packet latency ----------------
    do_reset();
    chk("rst_req_rdy", bus.req_rdy, 4'hF);
    chk("rst_pein_vld", bus.pein_vld, 1'b0);
    chk("rst_pein_pkt", bus.pein_pkt, 32'h0);
    chk("rst_inj_cnt", inj_cnt, 16'h0);
    chk("rst_stall_cnt", stall_cnt, 16'h0);

    bus.req_vld   = 4'b0001;
    set_pkt(0, 32'hA5);
    bus.peout_rdy = 1'b1;
    tick();                       // edge 1: push
    bus.req_vld = '0;
    chk("lat_vld_e1", bus.pein_vld, 1'b0);
    tick();                       // edge 2: lock
    chk("lat_vld_e2", bus.pein_vld, 1'b1);
    chk("lat_pkt_e2", bus.pein_pkt, 32'hA5);
    chk("lat_inj_e2", inj_cnt, 16'd0);
    tick();                       // edge 3: accept
    chk("lat_inj_e3", inj_cnt, 16'd1);
    chk("lat_vld_e3", bus.pein_vld, 1'b0);

    // ---------------- round-robin, all requesters with two packets ----------------
    do_reset();
    bus.req_vld   = 4'hF;
    bus.peout_rdy = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_pkt(i, hoplite_pkt_t'(i * 16));
    tick();                       // edge 1: first pushes
    for (int i = 0; i < N_REQ; i++) set_pkt(i, hoplite_pkt_t'(i * 16 + 1));
    tick();                       // edge 2: second pushes, lock req 0
    bus.req_vld = '0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_vld_%0d", k), bus.pein_vld, 1'b1);
      chk($sformatf("rr_pkt_%0d", k), bus.pein_pkt, 32'((k % 4) * 16 + k / 4));
      tick();
    end
    chk("rr_inj", inj_cnt, 16'd8);
    chk("rr_idle", bus.pein_vld, 1'b0);

    // ---------------- stall on requester 2, requester 1 fills ----------------
    do_reset();
    bus.req_vld = 4'b0100;
    set_pkt(2, 32'hC2);
    tick();                       // edge 1: push req 2
    bus.req_vld = 4'b0010;
    set_pkt(1, 32'hB1);
    tick();                       // edge 2: lock req 2, push B1
    chk("st_rdy1_one", bus.req_rdy[1], 1'b1);
    bus.req_vld = 4'b1010;
    set_pkt(1, 32'hB2);
    set_pkt(3, 32'hD3);
    chk("st_pkt_0", bus.pein_pkt, 32'hC2);
    tick();                       // edge 3: push B2 and D3, stall
    bus.req_vld = '0;
    chk("st_rdy1_full", bus.req_rdy[1], 1'b0);
    for (int k = 1; k < 6; k++) begin
      chk($sformatf("st_pkt_%0d", k), bus.pein_pkt, 32'hC2);
      chk($sformatf("st_vld_%0d", k), bus.pein_vld, 1'b1);
      if (k < 5) tick();          // edges 4..7 stall
    end
    bus.peout_rdy = 1'b1;
    tick();                       // edge 8: accept C2
    chk("st_stall_cnt", stall_cnt, 16'd5);
    chk("st_next_req3", bus.pein_pkt, 32'hD3);
    chk("st_inj1", inj_cnt, 16'd1);
    tick();                       // edge 9: accept D3, lock B1
    chk("st_pkt_b1", bus.pein_pkt, 32'hB1);
    chk("st_rdy1_still0", bus.req_rdy[1], 1'b0);
    tick();                       // edge 10: pop B1
    chk("st_pkt_b2", bus.pein_pkt, 32'hB2);
    chk("st_rdy1_back", bus.req_rdy[1], 1'b1);
    tick();                       // edge 11: accept B2
    chk("st_idle", bus.pein_vld, 1'b0);
    chk("st_inj4", inj_cnt, 16'd4);
    chk("st_stall_hold", stall_cnt, 16'd5);

    // ---------------- asynchronous reset while locked ----------------
    do_reset();
    bus.req_vld = 4'b0001;
    set_pkt(0, 32'h77);
    tick();                       // edge 1: push
    set_pkt(0, 32'h78);
    tick();                       // edge 2: lock, second push
    bus.req_vld = '0;
    tick();                       // edge 3: stall
    chk("ar_vld_pre", bus.pein_vld, 1'b1);
    chk("ar_stall_pre", stall_cnt, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_vld_async", bus.pein_vld, 1'b0);
    chk("ar_pkt_async", bus.pein_pkt, 32'h0);
    tick();
    rst_n = 1'b1;
    bus.peout_rdy = 1'b1;
    chk("ar_rdy", bus.req_rdy, 4'hF);
    chk("ar_inj", inj_cnt, 16'd0);
    chk("ar_stall", stall_cnt, 16'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ar_empty_%0d", k), bus.pein_vld, 1'b0);
    end

`ifdef HOPLITE_INJ_REGULATOR_EN
    // ---------------- regulator: BKT_MAX=2, refill every 8 cycles ----------------
    do_reset();
    bus.req_vld   = 4'b0001;
    set_pkt(0, 32'h55);
    bus.peout_rdy = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      tick();
      case (e)
        4:  chk("reg_e4", inj_cnt, 16'd2);
        7:  chk("reg_e7_idle", bus.pein_vld, 1'b0);
        9:  chk("reg_e9", inj_cnt, 16'd2);
        10: chk("reg_e10", inj_cnt, 16'd3);
        17: chk("reg_e17", inj_cnt, 16'd3);
        18: chk("reg_e18", inj_cnt, 16'd4);
        26: chk("reg_e26", inj_cnt, 16'd5);
        default: ;
      endcase
    end
    bus.req_vld = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hoplite_inj_ctrl.md
# hoplite_inj_ctrl

Injection controller that shares the single PE injection port of a Hoplite torus switch among N_REQ local requesters. Each requester pushes packets through a valid/ready handshake into a private 2-entry buffer. A round-robin arbiter then locks one buffer head onto pein_pkt/pein_vld and holds it stable until the switch accepts it via its same-cycle peout_rdy. An optional per-requester token-bucket regulator bounds injection rate for real-time analysis.

## Interface
- P_W, 32, packet width; same format as the switch.
- N_REQ, 4, number of requesters; 2..8.
- CNT_W, 16, width of the statistics counters.
- BKT_W, 4, token-bucket width (regulator only).
- BKT_MAX, 4, bucket capacity in tokens, ≤ 2^BKT_W−1 (regulator only).
- REFILL_PERIOD, 8, cycles per token refill (regulator only).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_pkt  in  N_REQ*P_W  requester packets; slice i belongs to requester i.
- req_vld  in  N_REQ  requester packet valid.
- req_rdy  out  N_REQ  buffer i can accept; registered.
- pein_pkt  out  P_W  to the switch pein_pkt.
- pein_vld  out  1  to the switch pein_vld.
- peout_rdy  in  1  switch accepted the PE packet this cycle; combinational from the switch.
- inj_cnt  out  CNT_W  packets accepted by the switch; saturating.
- stall_cnt  out  CNT_W  cycles with pein_vld=1 and peout_rdy=0; saturating.

## Operation
- Buffer i is a 2-entry FIFO.
  - Push when req_vld[i] & req_rdy[i].
  - Pop when i is locked & pein_vld & peout_rdy.
  - req_rdy[i] registered = (next occupancy < 2). Simultaneous push and pop on a full buffer is not allowed, because req_rdy is already 0.
- FSM states: IDLE and LOCKED; a lock index `win` is held while LOCKED.
  - IDLE: if any buffer is eligible, the next state is LOCKED. `win` = first eligible index at or after `rr_ptr`, scanning upward with wrap.
  - LOCKED: pein_vld=1 and pein_pkt = head of buffer `win`.
    - On peout_rdy=1: pop, set rr_ptr = win+1 (mod N_REQ) and re-arbitrate in the same cycle. If another eligible buffer exists, stay LOCKED with the new `win`. Otherwise go to IDLE. A buffer still holding a second entry is eligible, but is ranked last.
    - On peout_rdy=0: hold `win` and the packet unchanged. There is no re-arbitration and no withdrawal.
- Eligible means non-empty. With the regulator, it also requires tokens ≥ 1.
- The packet contents are not inspected or modified.
- inj_cnt increments on every accept. stall_cnt increments on every cycle that is LOCKED with peout_rdy=0. Both saturate at all-ones.

## Timing
- Reset values:
  - req_rdy all 1
  - pein_vld 0, pein_pkt 0
  - IDLE, rr_ptr 0
  - counters 0
  - buckets BKT_MAX, refill timer 0
- Latency: a push at edge t into an empty buffer, with the FSM in IDLE, gives pein_vld=1 after edge t+1.
- Back-to-back: an accept at t presents the next winner after edge t+1. There are no bubbles while any buffer is eligible.
- pein_vld and pein_pkt come straight from registers. peout_rdy feeds only next-state logic, so there is no combinational path from input to output.
- Reset asserted mid-packet: all buffered packets are dropped and pein_vld falls asynchronously.

## Configuration
- HOPLITE_INJ_REGULATOR_EN defined:
  - Each requester has a BKT_W bucket. An accept from requester i decrements bucket i.
  - Every REFILL_PERIOD cycles, all buckets below BKT_MAX increment by 1. If the refill and a decrement happen in the same cycle, the bucket is unchanged.
  - A requester with an empty bucket is ineligible. A locked packet is never revoked, because a token is required only at lock time.
- Undefined: there are no buckets or timer, eligibility = non-empty, and BKT_W, BKT_MAX and REFILL_PERIOD are ignored.

## Structure
- Shared package: the packet width constant and the packet field macros already used by the switch, plus a `hoplite_pkt_t` typedef. No new fields are added.
- One sub-module, `rr_arbiter`, is combinational: request vector + rr_ptr → one-hot grant + any. It is reused later for the ejection side.
- The buffers, FSM, counters and regulator live inline in `hoplite_inj_ctrl`.

## Test plan
- Reset, then req_vld[0]=1 with pkt 0xA5 at t=0 and peout_rdy tied to 1 → pein_vld=1, pkt=0xA5 at t=2; inj_cnt=1 at t=3.
- All 4 requesters keep 2 packets queued with peout_rdy=1 → grant order 0,1,2,3,0,1,2,3; inj_cnt=8 and no idle cycle after the first.
- Requester 2 locked, peout_rdy=0 for 5 cycles, then 1 → pkt stable for 6 cycles and stall_cnt=5; the next grant goes to requester 3.
- Requester 1 fills 2 entries while stalled → req_rdy[1]=0 the cycle after the second push; it returns to 1 the cycle after the pop.
- With the regulator on (BKT_MAX=2, REFILL_PERIOD=8) and only requester 0 busy with peout_rdy=1 → 2 accepts, then requester 0 is ineligible until refill; 1 accept per 8 cycles thereafter.
- rst low while LOCKED → pein_vld=0 immediately; after release, all buffers are empty, req_rdy are all 1 and the counters are 0.
